// File: rtl/fft_out_pkg.sv
// fft_out_pkg: shared sizes, state encoding and index bit-reversal for the FFT output sequencer.
package fft_out_pkg;
  localparam int N_SAMPLES  = 2048;
  localparam int SAMPLE_W   = 16;
  localparam int LINE_W     = 512;
  localparam int SPL        = LINE_W / SAMPLE_W;
  localparam int N_LINES    = N_SAMPLES / SPL;
  localparam int IDX_W      = 11;
  localparam int LINE_IDX_W = 6;
  typedef enum logic [1:0] {FILL, FETCH, CAPTURE, PRESENT} fft_out_state_t;
  function automatic logic [IDX_W-1:0] bitrev11(input logic [IDX_W-1:0] v);
    logic [IDX_W-1:0] r;
    for (int i = 0; i < IDX_W; i++) r[i] = v[IDX_W-1-i];
    return r;
  endfunction
endpackage

// File: rtl/fft_output_sequencer.sv
// fft_output_sequencer: fills the output buffer from the FFT stream, then drains it as 64 lines.
// Define FFT_OUT_BITREV_EN to store the bit-reversed FFT output in natural order.
module fft_output_sequencer
  import fft_out_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [SAMPLE_W-1:0]   in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  buf_wr_en,
  output logic [IDX_W-1:0]      buf_wr_index,
  output logic [SAMPLE_W-1:0]   buf_wr_data,
  output logic [LINE_IDX_W-1:0] buf_rd_index,
  input  logic [LINE_W-1:0]     buf_rd_data,
  output logic                  line_valid,
  input  logic                  line_ready,
  output logic [LINE_W-1:0]     line_data,
  output logic [LINE_IDX_W-1:0] line_index,
  output logic                  frame_done,
  output logic                  frame_err
);
  fft_out_state_t state_q, state_d;
  logic [IDX_W-1:0] wr_cnt_q, wr_cnt_d, wr_map;
  logic [LINE_IDX_W-1:0] ln_cnt_q, ln_cnt_d, rd_idx_q, line_index_q;
  logic [LINE_W-1:0] line_data_q;
  logic accept, wr_last, ln_last;
`ifdef FFT_OUT_BITREV_EN
  assign wr_map = bitrev11(wr_cnt_q);
`else
  assign wr_map = wr_cnt_q;
`endif
  assign accept  = (state_q == FILL) && in_valid;
  assign wr_last = wr_cnt_q == IDX_W'(N_SAMPLES - 1);
  assign ln_last = ln_cnt_q == LINE_IDX_W'(N_LINES - 1);
  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    ln_cnt_d = ln_cnt_q;
    case (state_q)
      FILL: begin
        wr_cnt_d = accept ? wr_cnt_q + 1'b1 : wr_cnt_q;
        state_d  = (accept && wr_last) ? FETCH : FILL;
      end
      FETCH:   state_d = CAPTURE;
      CAPTURE: state_d = PRESENT;
      PRESENT: begin
        ln_cnt_d = line_ready ? ln_cnt_q + 1'b1 : ln_cnt_q;
        state_d  = !line_ready ? PRESENT : ln_last ? FILL : FETCH;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      wr_cnt_q     <= '0;
      ln_cnt_q     <= '0;
      rd_idx_q     <= '0;
      line_data_q  <= '0;
      line_index_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      ln_cnt_q <= ln_cnt_d;
      if (state_q == FETCH) rd_idx_q <= ln_cnt_q;
      if (state_q == CAPTURE) begin
        line_data_q  <= buf_rd_data;
        line_index_q <= ln_cnt_q;
      end
    end
  end
  // Count alone sequences the frame; in_last only flags disagreement.
  assign in_ready     = state_q == FILL;
  assign buf_wr_en    = accept;
  assign buf_wr_index = accept ? wr_map : '0;
  assign buf_wr_data  = accept ? in_data : '0;
  assign frame_err    = accept && (in_last != wr_last);
  assign buf_rd_index = (state_q == FETCH) ? ln_cnt_q : rd_idx_q;
  assign line_valid   = state_q == PRESENT;
  assign line_data    = line_data_q;
  assign line_index   = line_index_q;
  assign frame_done   = (state_q == PRESENT) && line_ready && ln_last;
endmodule

// File: tb/tb_fft_output_sequencer.sv
// tb_fft_output_sequencer: directed and randomized frames checked against a buffer/frame reference model.
module tb_fft_output_sequencer;
  logic clk = 1'b0;
  logic rst, in_valid, in_last, in_ready, buf_wr_en, line_valid, line_ready, frame_done, frame_err;
  logic [15:0] in_data, buf_wr_data;
  logic [10:0] buf_wr_index;
  logic [5:0] buf_rd_index, line_index;
  logic [511:0] buf_rd_data, line_data, l0, l63;
  logic [15:0] mem [0:2047];
  logic [15:0] sent [0:2047];
  int errors = 0, checks = 0, done_cnt = 0, wr_seen = 0;

  always #5 clk = ~clk;

  fft_output_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .buf_wr_en(buf_wr_en), .buf_wr_index(buf_wr_index),
    .buf_wr_data(buf_wr_data), .buf_rd_index(buf_rd_index), .buf_rd_data(buf_rd_data),
    .line_valid(line_valid), .line_ready(line_ready), .line_data(line_data),
    .line_index(line_index), .frame_done(frame_done), .frame_err(frame_err)
  );

  // Buffer stand-in: sample writes, one-cycle-latency line reads.
  always @(posedge clk) begin
    if (buf_wr_en) mem[buf_wr_index] <= buf_wr_data;
    for (int j = 0; j < 32; j++) buf_rd_data[16*j +: 16] <= mem[32*int'(buf_rd_index) + j];
    if (!rst && frame_done) done_cnt <= done_cnt + 1;
    if (!rst && buf_wr_en) wr_seen <= wr_seen + 1;
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] tmap(input int i);
    logic [10:0] t, r;
    t = 11'(i);
`ifdef FFT_OUT_BITREV_EN
    r = {<<{t}};
`else
    r = t;
`endif
    return r;
  endfunction

  function automatic logic [511:0] exp_line(input int k);
    logic [511:0] l;
    for (int j = 0; j < 32; j++) l[16*j +: 16] = sent[32*k + j];
    return l;
  endfunction

  // vmode: 0 full rate, 1 every other cycle, 2 random valid
  task automatic fill(input int vmode, input bit rnd_data, input int last_at, input int n);
    int i, cyc, w0, bad_idx, bad_dat, bad_idle, bad_rdy, n_err, exp_err;
    i = 0; cyc = 0; w0 = wr_seen; bad_idx = 0; bad_dat = 0; bad_idle = 0; bad_rdy = 0;
    n_err = 0; exp_err = 0;
    while (i < n && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      in_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
      in_data  = rnd_data ? 16'($urandom) : 16'(i);
      in_last  = (i == last_at);
      #1;
      if (in_ready !== 1'b1) bad_rdy++;
      if (frame_err === 1'b1) n_err++;
      if (in_valid) begin
        if (buf_wr_en !== 1'b1 || buf_wr_index !== tmap(i)) bad_idx++;
        if (buf_wr_data !== in_data) bad_dat++;
        if (in_last != (i == 2047)) exp_err++;
        sent[tmap(i)] = in_data;
        i++;
      end else if (buf_wr_en !== 1'b0) bad_idle++;
    end
    @(posedge clk);
    #1;
    chk("fill_in_ready", bad_rdy, 0);
    chk("fill_wr_index", bad_idx, 0);
    chk("fill_wr_data", bad_dat, 0);
    chk("fill_idle_wr_en", bad_idle, 0);
    chk("fill_frame_err_count", n_err, exp_err);
    chk("fill_write_count", wr_seen - w0, n);
  endtask

  task automatic drain(input int stall_line, input bit rnd_ready);
    int d0, w, ns, bad_w, bad_ln, bad_st, bad_hold, bad_done;
    logic [511:0] hd;
    logic [5:0] hi;
    d0 = done_cnt; bad_w = 0; bad_ln = 0; bad_st = 0; bad_hold = 0; bad_done = 0;
    for (int k = 0; k < 64; k++) begin
      w = 0;
      do begin
        @(negedge clk);
        line_ready = 1'b0; in_valid = 1'b1; in_data = 16'($urandom); in_last = 1'b0;
        #1;
        w++;
        if (in_ready !== 1'b0 || buf_wr_en !== 1'b0) bad_st++;
      end while (line_valid !== 1'b1 && w < 10);
      if (w != 3) bad_w++;
      hd = line_data; hi = line_index;
      ns = (k == stall_line) ? 10 : rnd_ready ? int'($urandom_range(0, 3)) : 0;
      for (int s = 0; s < ns; s++) begin
        @(negedge clk);
        #1;
        if (line_valid !== 1'b1 || line_data !== hd || line_index !== hi || in_ready !== 1'b0) bad_hold++;
      end
      if (k == stall_line) chk("stall_line_index", line_index, 6'(stall_line));
      line_ready = 1'b1;
      #1;
      if (line_index !== 6'(k) || line_data !== exp_line(k)) bad_ln++;
      if (frame_done !== (k == 63)) bad_done++;
      if (k == 0) l0 = line_data;
      if (k == 63) l63 = line_data;
      @(posedge clk);
    end
    @(negedge clk);
    line_ready = 1'b0; in_valid = 1'b0;
    #1;
    chk("drain_line_latency", bad_w, 0);
    chk("drain_line_content", bad_ln, 0);
    chk("drain_input_stalled", bad_st, 0);
    chk("drain_hold_stable", bad_hold, 0);
    chk("drain_frame_done_timing", bad_done, 0);
    chk("drain_frame_done_count", done_cnt - d0, 1);
    chk("drain_end_line_valid", line_valid, 1'b0);
    chk("drain_end_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    int d0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; line_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_line_valid", line_valid, 1'b0);
    chk("rst_buf_wr_en", buf_wr_en, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_line_data", line_data, '0);
    chk("rst_line_index", line_index, 6'd0);
    chk("rst_buf_rd_index", buf_rd_index, 6'd0);
    // Ramp frame: sample value equals its stream position
    fill(0, 1'b0, 2047, 2048);
    drain(-1, 1'b0);
    chk("ramp_line0_slice0", l0[15:0], 16'd0);
`ifdef FFT_OUT_BITREV_EN
    chk("ramp_line0_slice1", l0[31:16], 16'd1024);
    chk("ramp_line0_slice31", l0[511:496], 16'd1984);
`else
    chk("ramp_line0_slice1", l0[31:16], 16'd1);
    chk("ramp_line0_slice31", l0[511:496], 16'd31);
`endif
    chk("ramp_line63_slice31", l63[511:496], 16'd2047);
    // Random data with random valid gaps; long stall on line 5
    fill(2, 1'b1, 2047, 2048);
    drain(5, 1'b0);
    // Valid every other cycle; random line backpressure
    fill(1, 1'b1, 2047, 2048);
    drain(-1, 1'b1);
    // Early in_last at 100 and none at 2047: two error pulses, full fill anyway
    fill(0, 1'b1, 100, 2048);
    drain(-1, 1'b1);
    // Reset in the middle of a fill
    d0 = done_cnt;
    fill(0, 1'b1, 2047, 700);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_line_valid", line_valid, 1'b0);
    chk("midrst_no_frame_done", done_cnt - d0, 0);
    fill(2, 1'b1, 2047, 2048);
    drain(-1, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
